// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in clk
// cycles and publishes each completed measurement over a valid/ready handshake.
module pwm_capture #(
    parameter int unsigned CNT_W       = 18,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = (32'd1 << CNT_W) - 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [2:0] ST_ARM       = 3'd0;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_HIGH      = 3'd3;
    localparam logic [2:0] ST_LOW       = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_prev_q, s_prev_d;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   timeout_q, timeout_d;
    logic                   overrun_q, overrun_d;

    logic s_c;
    logic rise_c;
    logic fall_c;
    logic publish_c;
    logic abandon_c;

    // Synchroniser chain and edge detection on the synchronised level
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s_c      = sync_q[SYNC_STAGES-1];
        s_prev_d = s_c;
        rise_c   = s_c & ~s_prev_q;
        fall_c   = ~s_c & s_prev_q;
    end

    // Measurement FSM: arm, find a clean low, then time rise->fall->rise
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_lat_d  = hi_lat_q;
        publish_c = 1'b0;
        abandon_c = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (cnt_q == ARM_LAST) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOW: begin
                if (!s_c) begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (rise_c) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt_q == TIMEOUT_VAL) begin
                    abandon_c = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (fall_c) begin
                        hi_lat_d = cnt_q;
                        state_d  = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (cnt_q == TIMEOUT_VAL) begin
                    abandon_c = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_RISE;
                end else if (rise_c) begin
                    publish_c = 1'b1;
                    cnt_d     = CNT_ONE;
                    state_d   = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_ARM;
                cnt_d   = '0;
            end
        endcase
    end

    // Output holding register with valid/ready handshake and sticky flags
    always_comb begin
        high_time_d  = high_time_q;
        period_d     = period_q;
        meas_valid_d = meas_valid_q;
        timeout_d    = timeout_q;
        overrun_d    = overrun_q;
        if (publish_c) begin
            if (!meas_valid_q || meas_ready) begin
                high_time_d  = hi_lat_q;
                period_d     = cnt_q;
                meas_valid_d = 1'b1;
                timeout_d    = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (meas_valid_q && meas_ready) begin
            meas_valid_d = 1'b0;
        end
        if (abandon_c) begin
            timeout_d = 1'b1;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            s_prev_q     <= 1'b0;
            state_q      <= ST_ARM;
            cnt_q        <= '0;
            hi_lat_q     <= '0;
            high_time_q  <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            s_prev_q     <= s_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_lat_q     <= hi_lat_d;
            high_time_q  <= high_time_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign high_time  = high_time_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM waveforms cycle by cycle and compares the DUT against a
// timestamp-based reference model of the measurement and output handshake.
module tb_pwm_capture;

    localparam int unsigned CW = 10;
    localparam int          TO = 1023;
    localparam int          LAT = 3;

    localparam int M_RST   = 0;
    localparam int M_WLOW  = 1;
    localparam int M_WRISE = 2;
    localparam int M_HI    = 3;
    localparam int M_LO    = 4;

    logic          clk;
    logic          reset;
    logic          pwm_in;
    logic          meas_ready;
    logic [CW-1:0] high_time;
    logic [CW-1:0] period;
    logic          meas_valid;
    logic          timeout;
    logic          overrun;

    typedef struct {
        int at;
        bit is_pub;
        int hi;
        int per;
    } ev_t;

    ev_t  evq[$];
    int   cyc;
    int   n_cmp;
    int   n_mis;
    int   m_mode;
    int   m_t;
    int   m_hi;
    logic m_prev;
    logic mv, mt, mo;
    int   mht, mper;

    pwm_capture #(
        .CNT_W      (CW),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .high_time (high_time),
        .period    (period),
        .meas_valid(meas_valid),
        .meas_ready(meas_ready),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output register behaviour at a clock edge: reset, delayed events, handshake
    task automatic model_edge();
        bit pub_now;
        bit tmo_now;
        int ph;
        int pp;
        pub_now = 1'b0;
        tmo_now = 1'b0;
        ph = 0;
        pp = 0;
        cyc++;
        if (reset) begin
            mv = 1'b0; mt = 1'b0; mo = 1'b0; mht = 0; mper = 0;
            evq.delete();
            m_mode = M_RST;
        end else begin
            while (evq.size() > 0 && evq[0].at == cyc) begin
                if (evq[0].is_pub) begin
                    pub_now = 1'b1;
                    ph = evq[0].hi;
                    pp = evq[0].per;
                end else begin
                    tmo_now = 1'b1;
                end
                evq.delete(0);
            end
            if (pub_now) begin
                if (!mv || meas_ready) begin
                    mht = ph; mper = pp; mv = 1'b1; mt = 1'b0;
                end else begin
                    mo = 1'b1;
                end
            end else if (mv && meas_ready) begin
                mv = 1'b0;
            end
            if (tmo_now) mt = 1'b1;
        end
    endtask

    task automatic sched(input bit is_pub, input int hi, input int per);
        ev_t e;
        e.at = cyc + LAT;
        e.is_pub = is_pub;
        e.hi = hi;
        e.per = per;
        evq.push_back(e);
    endtask

    // Pin-level measurement using rise/fall timestamps
    task automatic model_pin(input logic p);
        bit rise;
        bit fall;
        rise = p && !m_prev;
        fall = !p && m_prev;
        case (m_mode)
            M_RST:   m_mode = M_WLOW;
            M_WLOW:  if (!p) m_mode = M_WRISE;
            M_WRISE: if (rise) begin m_t = cyc; m_mode = M_HI; end
            M_HI: begin
                if (cyc - m_t == TO) begin
                    sched(1'b0, 0, 0);
                    m_mode = M_WLOW;
                end else if (fall) begin
                    m_hi = cyc - m_t;
                    m_mode = M_LO;
                end
            end
            default: begin
                if (cyc - m_t == TO) begin
                    sched(1'b0, 0, 0);
                    m_mode = M_WRISE;
                end else if (rise) begin
                    sched(1'b1, m_hi, cyc - m_t);
                    m_t = cyc;
                    m_mode = M_HI;
                end
            end
        endcase
        m_prev = p;
    endtask

    task automatic step(input logic pin, input logic rdy, input logic rst);
        @(posedge clk);
        model_edge();
        #1;
        pwm_in = pin;
        meas_ready = rdy;
        reset = rst;
        model_pin(pin);
        check_val("meas_valid", 32'(meas_valid), 32'(mv));
        check_val("timeout", 32'(timeout), 32'(mt));
        check_val("overrun", 32'(overrun), 32'(mo));
        check_val("high_time", 32'(high_time), 32'(mht));
        check_val("period", 32'(period), 32'(mper));
    endtask

    function automatic logic pick_rdy(input int rmode, input int i);
        case (rmode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return ($urandom_range(0, 3) != 0);
            default: return (i == 2);
        endcase
    endfunction

    task automatic run_pwm(input int hi, input int lo, input int nper, input int rmode);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < hi; i++) step(1'b1, pick_rdy(rmode, i), 1'b0);
            for (int i = 0; i < lo; i++) step(1'b0, pick_rdy(rmode, -1), 1'b0);
        end
    endtask

    task automatic hold(input logic pin, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(pin, rdy, 1'b0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        int lo;
        int nr;
        reset = 1'b1; pwm_in = 1'b0; meas_ready = 1'b1;
        cyc = 0; n_cmp = 0; n_mis = 0;
        m_mode = M_RST; m_t = 0; m_hi = 0; m_prev = 1'b0;
        mv = 1'b0; mt = 1'b0; mo = 1'b0; mht = 0; mper = 0;

        // Reset state
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        hold(1'b0, 1'b1, 6);
        check_val("rst_valid", 32'(meas_valid), 32'd0);

        // Ideal PWM, always ready
        run_pwm(20, 180, 5, 0);
        check_val("s1_high", 32'(high_time), 32'd20);
        check_val("s1_period", 32'(period), 32'd200);

        // Reset while pin high, released mid-pulse
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 180);
        run_pwm(20, 180, 3, 0);
        check_val("s2_high", 32'(high_time), 32'd20);
        check_val("s2_period", 32'(period), 32'd200);

        // High timeout, then resume
        run_pwm(20, 180, 2, 0);
        hold(1'b1, 1'b1, 1500);
        check_val("s3_tmo_hi", 32'(timeout), 32'd1);
        check_val("s3_novalid", 32'(meas_valid), 32'd0);
        hold(1'b0, 1'b1, 50);
        run_pwm(20, 180, 3, 0);
        check_val("s3_tmo_clr", 32'(timeout), 32'd0);
        check_val("s3_period", 32'(period), 32'd200);
        // Low timeout, then resume
        hold(1'b0, 1'b1, 1500);
        check_val("s3_tmo_lo", 32'(timeout), 32'd1);
        run_pwm(20, 180, 3, 0);
        check_val("s3_tmo_clr2", 32'(timeout), 32'd0);

        // Consumer stalled for 2.5 periods
        run_pwm(30, 170, 1, 1);
        run_pwm(40, 160, 1, 1);
        hold(1'b1, 1'b0, 50);
        hold(1'b0, 1'b0, 80);
        check_val("s4_overrun", 32'(overrun), 32'd1);
        check_val("s4_held_v", 32'(meas_valid), 32'd1);
        check_val("s4_held_hi", 32'(high_time), 32'd20);
        check_val("s4_held_per", 32'(period), 32'd200);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_val("s4_accept", 32'(meas_valid), 32'd0);
        check_val("s4_sticky", 32'(overrun), 32'd1);
        hold(1'b0, 1'b0, 68);
        run_pwm(20, 180, 1, 0);

        // Accept exactly on the publishing edge
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);
        hold(1'b0, 1'b0, 5);
        run_pwm(10, 100, 1, 3);
        run_pwm(15, 100, 1, 3);
        run_pwm(25, 100, 1, 3);
        run_pwm(30, 100, 1, 3);
        check_val("s5_valid", 32'(meas_valid), 32'd1);
        check_val("s5_overrun", 32'(overrun), 32'd0);
        check_val("s5_high", 32'(high_time), 32'd25);
        check_val("s5_period", 32'(period), 32'd125);

        // One-cycle reset while measuring the high phase
        run_pwm(20, 180, 2, 0);
        hold(1'b1, 1'b1, 10);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check_val("s6_valid", 32'(meas_valid), 32'd0);
        check_val("s6_high", 32'(high_time), 32'd0);
        check_val("s6_period", 32'(period), 32'd0);
        hold(1'b1, 1'b1, 8);
        hold(1'b0, 1'b1, 180);
        run_pwm(20, 180, 3, 0);
        check_val("s6_high2", 32'(high_time), 32'd20);
        check_val("s6_period2", 32'(period), 32'd200);

        // Random waveforms, random ready, occasional long phases and resets
        for (int k = 0; k < 80; k++) begin
            hi = $urandom_range(1, 60);
            lo = $urandom_range(1, 80);
            if ($urandom_range(0, 14) == 0) hi = $urandom_range(1030, 1200);
            else if ($urandom_range(0, 14) == 0) lo = $urandom_range(1030, 1200);
            run_pwm(hi, lo, 1, 2);
            if ($urandom_range(0, 24) == 0) begin
                nr = $urandom_range(1, 3);
                for (int j = 0; j < nr; j++) step(pwm_in, 1'b1, 1'b1);
            end
        end
        hold(1'b0, 1'b1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
